mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 SHALL have parameter: HOLD_MAX, 8, max consecutive cycles one owner keeps the grant while others wait; legal range 1..255.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port: req  input  4  level requests; bit i = requester i wants the shared 4-input mux.
REQ-005 SHALL have port: gnt  output  4  one-hot grant; all-zero when no owner.
REQ-006 SHALL have port: sel  output  2  mux select; equals the index of the set gnt bit.
REQ-007 SHALL have port: valid  output  1  high while any gnt bit is set.
REQ-008 SHALL have port: switched  output  1  one-cycle pulse in the cycle a new owner's gnt first appears.

Function
REQ-009 SHALL be a two-state FSM: IDLE (no owner), GRANT (owner held).
REQ-010 SHALL register all outputs; the arbitration decision uses req sampled at edge N, and the result is visible after edge N (1-cycle latency).
REQ-011 SHALL hold a 2-bit priority pointer ptr; winner = first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-012 SHALL set ptr = winner+1 mod 4 on every new grant (3 wraps to 0).
REQ-013 IDLE, req==0: SHALL stay in IDLE with gnt=0 and valid=0; sel SHALL keep its last value.
REQ-014 IDLE, req!=0: SHALL go to GRANT; gnt=onehot(winner), sel=winner, valid=1, switched=1, hold_cnt=1.
REQ-015 GRANT, req[owner]=0, other req pending: SHALL hand over directly to the new winner (no idle bubble); switched=1, hold_cnt=1.
REQ-016 GRANT, req[owner]=0, no other req: SHALL go to IDLE; gnt=0, valid=0, switched=0.
REQ-017 GRANT, req[owner]=1, hold_cnt<HOLD_MAX: SHALL keep the owner and increment hold_cnt.
REQ-018 GRANT, req[owner]=1, hold_cnt==HOLD_MAX, another req pending: SHALL preempt; the winner is searched from ptr with the owner bit masked; switched=1, hold_cnt=1.
REQ-019 GRANT, req[owner]=1, hold_cnt==HOLD_MAX, no other req: SHALL keep the owner; hold_cnt saturates at HOLD_MAX and never wraps.
REQ-020 switched SHALL be 0 in every cycle that does not start a new owner, including re-grant to the same index after an IDLE gap (that IDLE->GRANT cycle pulses per REQ-014).
REQ-021 gnt SHALL never have more than one bit set; sel SHALL match gnt whenever valid=1.
REQ-022 HOLD_MAX=1 SHALL rotate the grant every cycle among contending requesters.

Reset
REQ-023 reset=1 at a rising edge SHALL force: state IDLE, gnt=0, sel=0, valid=0, switched=0, ptr=0, hold_cnt=0.
REQ-024 reset SHALL override all other inputs, including mid-grant; the first arbitration after reset deasserts SHALL start from ptr=0.
REQ-025 Outputs SHALL be deterministic from the first reset edge; X on outputs after reset is a failure.

Verification
REQ-026 SHALL cover: reset, then req=4'b1010 for 1 cycle -> next cycle gnt=4'b0010, sel=1, valid=1, switched=1; ptr=2.
REQ-027 SHALL cover: req=4'b1111 held, HOLD_MAX=8 -> owners 0,1,2,3,0 in sequence, each exactly 8 cycles; switched pulses every 8th cycle.
REQ-028 SHALL cover: owner 2 holds, req changes from 4'b0100 to 4'b0001 at one edge -> gnt=4'b0001 the next cycle, with no cycle of valid=0.
REQ-029 SHALL cover: only req[3] held for 20 cycles -> gnt=4'b1000 throughout, hold_cnt saturates at 8, switched pulses only on the first cycle.
REQ-030 SHALL cover: reset asserted at cycle 3 of a grant to requester 1 with req=4'b0011 -> outputs zero during reset; after release, requester 0 wins first (ptr=0).
REQ-031 SHALL cover: HOLD_MAX=1, req=4'b0101 -> gnt alternates 4'b0001, 4'b0100 every cycle, and one-hot is checked by an assertion every cycle.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//    Round-robin arbiter that owns the select of a shared 4-input mux.
//    An owner keeps the grant while it requests, for at most HOLD_MAX
//    consecutive cycles if someone else is waiting. Ownership passes
//    straight to the next winner without an idle bubble. All outputs are
//    registered, so a decision made from req at edge N shows after edge N.
//
// Ports
//    clk       single clock, rising edge
//    reset     synchronous, active-high
//    req[3:0]  level requests, bit i = requester i
//    gnt[3:0]  one-hot grant, zero when there is no owner
//    sel[1:0]  mux select, index of the granted requester (kept while idle)
//    valid     high while a grant is held
//    switched  one-cycle pulse in the first cycle of a new owner
//
// state | meaning
// IDLE  | no owner, gnt=0
// GRANT | one owner holds gnt, hold_cnt counts its consecutive cycles

module mux_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       valid,
   output logic       switched
);

   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] hold_cnt, hold_d;
   logic [3:0] gnt_d;
   logic [1:0] sel_d;
   logic       valid_d, switched_d;

   logic [3:0] others;
   logic       owner_req;
   logic [2:0] pick_any, pick_oth;
   logic       take;
   logic [1:0] win;

   // Returns {found, index} of the first set bit scanning p, p+1, p+2, p+3.
   // The loop runs from the farthest offset down so the nearest one wins.
   function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = p + i[1:0];
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // The owner bit is masked out so a preemption or handover always lands on
   // a different requester.
   assign others    = req & ~gnt;
   assign owner_req = |(req & gnt);
   assign pick_any  = pick(req, ptr_q);
   assign pick_oth  = pick(others, ptr_q);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_d     = hold_cnt;
      gnt_d      = gnt;
      sel_d      = sel;
      valid_d    = valid;
      switched_d = 1'b0;
      take       = 1'b0;
      win        = 2'd0;

      case (state_q)
         IDLE: begin
            if (pick_any[2]) begin
               take = 1'b1;
               win  = pick_any[1:0];
            end else begin
               gnt_d   = 4'b0000;
               valid_d = 1'b0;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               if (pick_oth[2]) begin
                  take = 1'b1;
                  win  = pick_oth[1:0];
               end else begin
                  state_d = IDLE;
                  gnt_d   = 4'b0000;
                  valid_d = 1'b0;
                  hold_d  = 8'd0;
               end
            end else if (hold_cnt < HOLD_LIM) begin
               hold_d = hold_cnt + 8'd1;
            end else if (pick_oth[2]) begin
               take = 1'b1;
               win  = pick_oth[1:0];
            end
            // otherwise the lone owner keeps the grant, hold_cnt saturated
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
         end
      endcase

      if (take) begin
         state_d    = GRANT;
         gnt_d      = 4'b0001 << win;
         sel_d      = win;
         valid_d    = 1'b1;
         switched_d = 1'b1;
         ptr_d      = win + 2'd1;
         hold_d     = 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= 2'd0;
         hold_cnt <= 8'd0;
         gnt      <= 4'b0000;
         sel      <= 2'd0;
         valid    <= 1'b0;
         switched <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         hold_cnt <= hold_d;
         gnt      <= gnt_d;
         sel      <= sel_d;
         valid    <= valid_d;
         switched <= switched_d;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] req8, req1;
   logic [3:0] gnt8, gnt1;
   logic [1:0] sel8, sel1;
   logic       valid8, valid1, sw8, sw1;

   int checks = 0;
   int errors = 0;

   mux_rr_arbiter #(.HOLD_MAX(8)) dut8 (
      .clk(clk), .reset(reset), .req(req8),
      .gnt(gnt8), .sel(sel8), .valid(valid8), .switched(sw8)
   );

   mux_rr_arbiter #(.HOLD_MAX(1)) dut1 (
      .clk(clk), .reset(reset), .req(req1),
      .gnt(gnt1), .sel(sel1), .valid(valid1), .switched(sw1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle before looking at outputs.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string tag, input logic [3:0] g, input logic [1:0] s,
                       input logic v, input logic w);
      chk({tag, ".gnt"}, 32'(gnt8), 32'(g));
      chk({tag, ".sel"}, 32'(sel8), 32'(s));
      chk({tag, ".valid"}, 32'(valid8), 32'(v));
      chk({tag, ".switched"}, 32'(sw8), 32'(w));
   endtask

   // Structural invariants on both instances every cycle, once past reset.
   logic armed = 1'b0;
   always @(negedge clk) begin
      if (armed) begin
         checks++;
         assert ($onehot0(gnt8) && $onehot0(gnt1)
                 && (valid8 === (gnt8 != 4'b0)) && (valid1 === (gnt1 != 4'b0))
                 && (!valid8 || gnt8 === (4'b0001 << sel8))
                 && (!valid1 || gnt1 === (4'b0001 << sel1))) else begin
            errors++;
            $error("FAIL onehot: observed gnt8=%b sel8=%0d gnt1=%b sel1=%0d expected one-hot matching sel",
                   gnt8, sel8, gnt1, sel1);
         end
      end
   end

   initial begin
      reset = 1'b1;
      req8  = 4'b0000;
      req1  = 4'b0000;

      // reset state
      step();
      step();
      armed = 1'b1;
      chk8("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

      // first grant after reset: 1010 from ptr 0 -> requester 1, ptr becomes 2
      reset = 1'b0;
      req8  = 4'b1010;
      step();
      chk8("first", 4'b0010, 2'd1, 1'b1, 1'b1);
      chk("first.ptr", 32'(dut8.ptr_q), 32'd2);

      // owner drops, nobody else -> idle, sel keeps last value
      req8 = 4'b0000;
      step();
      chk8("drop", 4'b0000, 2'd1, 1'b0, 1'b0);
      step();
      chk8("idle", 4'b0000, 2'd1, 1'b0, 1'b0);

      // re-grant of the same index after an idle gap still pulses switched
      req8 = 4'b0010;
      step();
      chk8("regrant", 4'b0010, 2'd1, 1'b1, 1'b1);
      step();
      chk8("regrant.hold", 4'b0010, 2'd1, 1'b1, 1'b0);

      // all four requesting: owners 0,1,2,3,0 for 8 cycles each
      reset = 1'b1;
      req8  = 4'b0000;
      step();
      reset = 1'b0;
      req8  = 4'b1111;
      for (int o = 0; o < 5; o++) begin
         for (int c = 0; c < 8; c++) begin
            step();
            chk8($sformatf("rot.o%0d.c%0d", o, c), 4'b0001 << (o % 4), 2'(o % 4),
                 1'b1, (c == 0));
         end
      end

      // owner 2 holds, then req moves to requester 0 with no idle bubble
      reset = 1'b1;
      req8  = 4'b0000;
      step();
      reset = 1'b0;
      req8  = 4'b0100;
      step();
      chk8("own2", 4'b0100, 2'd2, 1'b1, 1'b1);
      step();
      chk8("own2.hold", 4'b0100, 2'd2, 1'b1, 1'b0);
      req8 = 4'b0001;
      step();
      chk8("handover", 4'b0001, 2'd0, 1'b1, 1'b1);

      // lone requester 3 for 20 cycles: no preemption, hold_cnt saturates
      reset = 1'b1;
      req8  = 4'b0000;
      step();
      reset = 1'b0;
      req8  = 4'b1000;
      for (int i = 0; i < 20; i++) begin
         step();
         chk8($sformatf("lone.c%0d", i), 4'b1000, 2'd3, 1'b1, (i == 0));
         if (i == 8) chk("lone.hold8", 32'(dut8.hold_cnt), 32'd8);
      end
      chk("lone.hold_end", 32'(dut8.hold_cnt), 32'd8);

      // reset mid-grant of requester 1, then requester 0 wins from ptr 0
      reset = 1'b1;
      req8  = 4'b0000;
      step();
      reset = 1'b0;
      req8  = 4'b0010;
      step();
      chk8("mid.c1", 4'b0010, 2'd1, 1'b1, 1'b1);
      req8 = 4'b0011;
      step();
      step();
      chk8("mid.c3", 4'b0010, 2'd1, 1'b1, 1'b0);
      reset = 1'b1;
      step();
      chk8("mid.reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      step();
      chk8("mid.after", 4'b0001, 2'd0, 1'b1, 1'b1);
      chk("mid.ptr", 32'(dut8.ptr_q), 32'd1);

      // ptr really restarts at 0: 0110 must go to requester 1, not 2
      reset = 1'b1;
      step();
      reset = 1'b0;
      req8  = 4'b0110;
      step();
      chk8("ptr0", 4'b0010, 2'd1, 1'b1, 1'b1);

      // HOLD_MAX=1 with 0101: grant alternates every cycle
      req1 = 4'b0101;
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("hm1.gnt.c%0d", i), 32'(gnt1), (i % 2 == 0) ? 32'h1 : 32'h4);
         chk($sformatf("hm1.sw.c%0d", i), 32'(sw1), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
